btop_ctrl: RTL and testbench

BTOP_CTRL -- requirements
Module: btop_ctrl

---
 rtl/btop_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_btop_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/btop_ctrl.sv
// Burst controller: arbitrates write and read bursts over a slot-mapped storage,
// drives storage enables and slot indices, and tracks written slots in a scoreboard.
module btop_ctrl #(
  parameter int N = 1024,
  parameter int P = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [3:0] wr_beats,
  input  logic       rd_req,
  input  logic [3:0] rd_beats,
  input  logic       flush,
  output logic       wr_ack,
  output logic       rd_ack,
  output logic       wr_done,
  output logic       rd_done,
  output logic       w_en,
  output logic       r_en,
  output logic [3:0] cnta,
  output logic [3:0] cntb,
  output logic       rd_valid,
  output logic       busy,
  output logic       err
);

  localparam int         WS   = N / (4 * P);
  localparam int         RS   = N / (2 * P);
  localparam logic [3:0] WS_L = 4'(WS);
  localparam logic [3:0] RS_L = 4'(RS);

  typedef enum logic [1:0] {IDLE, WR, RD, RDRAIN} state_t;

  state_t          state_q, state_n;
  logic [3:0]      cnt_q, cnt_n;
  logic [3:0]      len_q, len_n;
  logic [WS-1:0]   sb_q, sb_n;
  logic            wr_pri_q, wr_pri_n;
  logic            wr_blk_q, wr_blk_n, rd_blk_q, rd_blk_n;
  logic [3:0]      wr_blk_len_q, wr_blk_len_n, rd_blk_len_q, rd_blk_len_n;

  logic            wr_ack_n, rd_ack_n, wr_done_n, rd_done_n;
  logic            w_en_n, r_en_n, rd_valid_n, busy_n, err_n;
  logic [3:0]      cnta_n, cntb_n;

  logic            wr_legal, rd_legal, wr_hit, rd_hit, wr_bad, rd_bad;
  logic            wr_ok, rd_ok, rd_cover;
  logic [3:0]      rd_need;

  // Request qualification. A rejected illegal request stays ignored while it
  // is held unchanged, so a flush is not immediately undone by the same request.
  always_comb begin
    wr_legal = (wr_beats != 4'd0) && (wr_beats <= WS_L);
    rd_legal = (rd_beats != 4'd0) && (rd_beats <= RS_L);
    wr_hit   = wr_blk_q && wr_req && (wr_beats == wr_blk_len_q);
    rd_hit   = rd_blk_q && rd_req && (rd_beats == rd_blk_len_q);
    wr_bad   = wr_req && !wr_legal && !wr_hit;
    rd_bad   = rd_req && !rd_legal && !rd_hit;
    wr_ok    = wr_req && wr_legal;

    // Read slot k lands on write slot k mod WS, so only the first min(len,WS) matter.
    rd_need  = (rd_beats > WS_L) ? WS_L : rd_beats;
    rd_cover = 1'b1;
    for (int i = 0; i < WS; i++) begin
      if ((4'(i) < rd_need) && !sb_q[i]) rd_cover = 1'b0;
    end
    rd_ok = rd_req && rd_legal && rd_cover;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    len_n        = len_q;
    sb_n         = sb_q;
    wr_pri_n     = wr_pri_q;
    wr_blk_n     = wr_hit;
    rd_blk_n     = rd_hit;
    wr_blk_len_n = wr_blk_len_q;
    rd_blk_len_n = rd_blk_len_q;
    err_n        = err;
    wr_ack_n     = 1'b0;
    rd_ack_n     = 1'b0;
    wr_done_n    = 1'b0;
    rd_done_n    = 1'b0;
    w_en_n       = 1'b0;
    r_en_n       = 1'b0;
    cnta_n       = 4'd0;
    cntb_n       = 4'd0;
    rd_valid_n   = r_en;

    unique case (state_q)
      IDLE: begin
        if (wr_bad) begin
          wr_blk_n     = 1'b1;
          wr_blk_len_n = wr_beats;
          err_n        = 1'b1;
        end
        if (rd_bad) begin
          rd_blk_n     = 1'b1;
          rd_blk_len_n = rd_beats;
          err_n        = 1'b1;
        end
        if (flush) begin
          sb_n  = '0;
          err_n = 1'b0;
        end else if (wr_ok && (!rd_ok || wr_pri_q)) begin
          state_n   = WR;
          wr_ack_n  = 1'b1;
          w_en_n    = 1'b1;
          wr_done_n = (wr_beats == 4'd1);
          cnt_n     = 4'd1;
          len_n     = wr_beats;
          sb_n[0]   = 1'b1;
          wr_pri_n  = 1'b0;
        end else if (rd_ok) begin
          state_n   = RD;
          rd_ack_n  = 1'b1;
          r_en_n    = 1'b1;
          cnt_n     = 4'd1;
          len_n     = rd_beats;
          wr_pri_n  = 1'b1;
        end
      end

      WR: begin
        if (cnt_q == len_q) begin
          state_n = IDLE;
        end else begin
          w_en_n    = 1'b1;
          cnta_n    = cnt_q;
          cnt_n     = cnt_q + 4'd1;
          wr_done_n = ((cnt_q + 4'd1) == len_q);
          for (int i = 0; i < WS; i++) begin
            if (4'(i) == cnt_q) sb_n[i] = 1'b1;
          end
        end
      end

      RD: begin
        if (cnt_q == len_q) begin
          // The last read's data emerges in the drain cycle.
          state_n   = RDRAIN;
          rd_done_n = 1'b1;
        end else begin
          r_en_n = 1'b1;
          cntb_n = cnt_q;
          cnt_n  = cnt_q + 4'd1;
        end
      end

      RDRAIN: state_n = IDLE;

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      len_q        <= 4'd0;
      sb_q         <= '0;
      wr_pri_q     <= 1'b1;
      wr_blk_q     <= 1'b0;
      rd_blk_q     <= 1'b0;
      wr_blk_len_q <= 4'd0;
      rd_blk_len_q <= 4'd0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
      w_en         <= 1'b0;
      r_en         <= 1'b0;
      cnta         <= 4'd0;
      cntb         <= 4'd0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      len_q        <= len_n;
      sb_q         <= sb_n;
      wr_pri_q     <= wr_pri_n;
      wr_blk_q     <= wr_blk_n;
      rd_blk_q     <= rd_blk_n;
      wr_blk_len_q <= wr_blk_len_n;
      rd_blk_len_q <= rd_blk_len_n;
      wr_ack       <= wr_ack_n;
      rd_ack       <= rd_ack_n;
      wr_done      <= wr_done_n;
      rd_done      <= rd_done_n;
      w_en         <= w_en_n;
      r_en         <= r_en_n;
      cnta         <= cnta_n;
      cntb         <= cntb_n;
      rd_valid     <= rd_valid_n;
      busy         <= busy_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_btop_ctrl.sv
// Directed bench for btop_ctrl: cycle-by-cycle output vectors with
// hand-computed expectations, checked one cycle at a time.
module tb_btop_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req, flush;
  logic [3:0] wr_beats, rd_beats;
  logic       wr_ack, rd_ack, wr_done, rd_done, w_en, r_en, rd_valid, busy, err;
  logic [3:0] cnta, cntb;

  int n_tests = 0;
  int n_fail  = 0;

  btop_ctrl #(.N(1024), .P(64)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_beats(wr_beats),
    .rd_req(rd_req), .rd_beats(rd_beats),
    .flush(flush),
    .wr_ack(wr_ack), .rd_ack(rd_ack),
    .wr_done(wr_done), .rd_done(rd_done),
    .w_en(w_en), .r_en(r_en),
    .cnta(cnta), .cntb(cntb),
    .rd_valid(rd_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // {wr_ack, rd_ack, wr_done, rd_done, w_en, r_en, cnta, cntb, rd_valid, busy, err}
  logic [16:0] obs;
  assign obs = {wr_ack, rd_ack, wr_done, rd_done, w_en, r_en, cnta, cntb, rd_valid, busy, err};

  function automatic logic [16:0] ev(int wa, int ra, int wd, int rdn, int we, int re,
                                     int ca, int cb, int rv, int bz, int er);
    return {1'(wa), 1'(ra), 1'(wd), 1'(rdn), 1'(we), 1'(re), 4'(ca), 4'(cb),
            1'(rv), 1'(bz), 1'(er)};
  endfunction

  function automatic logic [16:0] idle(int er);
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er);
  endfunction

  function automatic logic [16:0] wbeat(int ack, int ca, int done);
    return ev(ack, 0, done, 0, 1, 0, ca, 0, 0, 1, 0);
  endfunction

  function automatic logic [16:0] rbeat(int ack, int cb, int rv);
    return ev(0, ack, 0, 0, 0, 1, 0, cb, rv, 1, 0);
  endfunction

  function automatic logic [16:0] rdrain();
    return ev(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
    n_tests++;
    assert (got === want)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
  endtask

  // Advance one clock edge, then compare the new cycle's outputs.
  task automatic cyc(input string tag, input logic [16:0] want);
    @(posedge clk);
    #1;
    check(tag, obs, want);
  endtask

  task automatic check_sb(input string tag, input logic [3:0] want);
    check(tag, 17'(dut.sb_q), 17'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    wr_beats = 4'd0;
    rd_beats = 4'd0;

    // Reset state
    #1;
    check("reset_outputs", obs, idle(0));
    cyc("reset_hold", idle(0));
    check_sb("reset_sb", 4'b0000);
    rst = 1'b1;
    cyc("post_reset_idle", idle(0));

    // Full 4-beat write
    wr_req = 1'b1; wr_beats = 4'd4;
    cyc("w4_beat0", wbeat(1, 0, 0));
    wr_req = 1'b0; wr_beats = 4'd0;
    cyc("w4_beat1", wbeat(0, 1, 0));
    cyc("w4_beat2", wbeat(0, 2, 0));
    cyc("w4_beat3", wbeat(0, 3, 1));
    check_sb("w4_sb", 4'b1111);
    cyc("w4_idle", idle(0));

    // Full 8-beat read, with a mid-burst length change that must be ignored
    rd_req = 1'b1; rd_beats = 4'd8;
    cyc("r8_beat0", rbeat(1, 0, 0));
    rd_req = 1'b0; rd_beats = 4'd2;
    for (int k = 1; k < 8; k++) cyc("r8_beat", rbeat(0, k, 1));
    cyc("r8_drain", rdrain());
    cyc("r8_idle", idle(0));

    // Both eligible and held: write, read, write
    wr_req = 1'b1; wr_beats = 4'd1;
    rd_req = 1'b1; rd_beats = 4'd1;
    cyc("rr_w1", wbeat(1, 0, 1));
    cyc("rr_gap1", idle(0));
    cyc("rr_r1", rbeat(1, 0, 0));
    cyc("rr_r1_drain", rdrain());
    cyc("rr_gap2", idle(0));
    cyc("rr_w2", wbeat(1, 0, 1));
    wr_req = 1'b0; rd_req = 1'b0;
    cyc("rr_idle", idle(0));

    // Illegal lengths set err with no grant; flush clears err and scoreboard
    wr_req = 1'b1; wr_beats = 4'd5;
    cyc("bad_w5", idle(1));
    cyc("bad_w5_hold", idle(1));
    flush = 1'b1;
    cyc("flush_clear", idle(0));
    flush = 1'b0;
    cyc("bad_w5_ignored", idle(0));
    check_sb("flush_sb", 4'b0000);
    wr_req = 1'b0; wr_beats = 4'd0;
    rd_req = 1'b1; rd_beats = 4'd9;
    cyc("bad_r9", idle(1));
    rd_req = 1'b0; rd_beats = 4'd0;
    flush = 1'b1;
    cyc("flush2", idle(0));
    flush = 1'b0;

    // Read blocked on empty scoreboard; write served first, then the read
    rd_req = 1'b1; rd_beats = 4'd2;
    cyc("rblk_0", idle(0));
    cyc("rblk_1", idle(0));
    wr_req = 1'b1; wr_beats = 4'd2;
    cyc("rblk_w0", wbeat(1, 0, 0));
    wr_req = 1'b0;
    cyc("rblk_w1", wbeat(0, 1, 1));
    check_sb("rblk_sb", 4'b0011);
    cyc("rblk_gap", idle(0));
    cyc("rblk_r0", rbeat(1, 0, 0));
    rd_req = 1'b0;
    cyc("rblk_r1", rbeat(0, 1, 1));
    cyc("rblk_drain", rdrain());
    cyc("rblk_idle", idle(0));

    // Reset during the third write beat
    wr_req = 1'b1; wr_beats = 4'd4;
    cyc("rstw_beat0", wbeat(1, 0, 0));
    wr_req = 1'b0;
    cyc("rstw_beat1", wbeat(0, 1, 0));
    cyc("rstw_beat2", wbeat(0, 2, 0));
    rst = 1'b0;
    #1;
    check("rstw_async_zero", obs, idle(0));
    check_sb("rstw_sb", 4'b0000);
    wr_req = 1'b1; wr_beats = 4'd3;
    cyc("rstw_held", idle(0));
    rst = 1'b1;
    cyc("rstw_first_grant", wbeat(1, 0, 0));
    wr_req = 1'b0;
    cyc("rstw_g_beat1", wbeat(0, 1, 0));
    cyc("rstw_g_beat2", wbeat(0, 2, 1));
    cyc("rstw_g_idle", idle(0));
    check_sb("rstw_g_sb", 4'b0111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
